// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retirement trace buffer: the per-instruction retire record
// and the width of the retired-instruction counter.
package retire_trace_buffer_pkg;

  localparam int XLEN      = 32;
  localparam int INSTRET_W = 64;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_wrt;
  } retire_rec_t;

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Retire-side and drain-side handshake bundle of the trace buffer.
// The master modport is the core/consumer side; the slave modport is the buffer.
interface retire_trace_buffer_if #(
  parameter int IssueWidth = 2,
  parameter int DrainWidth = 1
);
  import retire_trace_buffer_pkg::*;

  logic        [IssueWidth-1:0] ret_valid;
  retire_rec_t [IssueWidth-1:0] ret_rec;
  logic                         ret_ready;
  logic        [DrainWidth-1:0] drain_valid;
  retire_rec_t [DrainWidth-1:0] drain_rec;
  logic                         drain_ready;

  modport master (
    output ret_valid, ret_rec, drain_ready,
    input  ret_ready, drain_valid, drain_rec
  );

  modport slave (
    input  ret_valid, ret_rec, drain_ready,
    output ret_ready, drain_valid, drain_rec
  );

endinterface

// File: rtl/retire_trace_buffer_compactor.sv
// Prefix popcount over the retire lanes: each valid lane gets its slot offset
// relative to the write pointer, so sparse lanes pack densely in program order.
module retire_compactor #(
  parameter  int IssueWidth = 2,
  localparam int OffW       = $clog2(IssueWidth + 1)
) (
  input  logic [IssueWidth-1:0]           valid,
  output logic [IssueWidth-1:0][OffW-1:0] offset,
  output logic [OffW-1:0]                 total
);

  logic [OffW-1:0] running;

  always_comb begin
    running = '0;
    offset  = '0;
    for (int i = 0; i < IssueWidth; i++) begin
      offset[i] = running;
      running   = running + OffW'(valid[i]);
    end
    total = running;
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Circular trace buffer for retired instructions: compacts up to IssueWidth lanes per
// cycle, drains DrainWidth per cycle, and tracks instret and a sticky overflow flag.
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int IssueWidth = 2,
  parameter int DrainWidth = 1,
  parameter int Depth      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  retire_trace_buffer_if.slave       bus,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic [INSTRET_W-1:0]       instret_o,
  output logic                       overflow_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);
  localparam int OffW = $clog2(IssueWidth + 1);
  localparam int DrW  = $clog2(DrainWidth + 1);

  retire_rec_t                 mem [Depth];
  logic [PtrW-1:0]             rd_ptr;
  logic [PtrW-1:0]             wr_ptr;
  logic [CntW-1:0]             count;
  logic [INSTRET_W-1:0]        instret;
  logic                        overflow;

  logic [IssueWidth-1:0][OffW-1:0] lane_off;
  logic [OffW-1:0]                 push_total;
  logic [OffW-1:0]                 push_acc;
  logic [CntW-1:0]                 free_slots;
  logic                            accept;
  logic [DrW-1:0]                  avail;
  logic [DrW-1:0]                  pop_cnt;

  retire_compactor #(.IssueWidth(IssueWidth)) u_compactor (
    .valid  (bus.ret_valid),
    .offset (lane_off),
    .total  (push_total)
  );

  // Acceptance uses the pre-pop count, so a push never claims slots freed this cycle.
  always_comb begin
    free_slots = CntW'(Depth) - count;
    accept     = CntW'(push_total) <= free_slots;
    push_acc   = accept ? push_total : '0;
    avail      = (count < CntW'(DrainWidth)) ? DrW'(count) : DrW'(DrainWidth);
    pop_cnt    = bus.drain_ready ? avail : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      instret  <= '0;
      overflow <= 1'b0;
    end else begin
      if (!accept) begin
        overflow <= 1'b1;
      end
      wr_ptr  <= wr_ptr + PtrW'(push_acc);
      rd_ptr  <= rd_ptr + PtrW'(pop_cnt);
      count   <= count + CntW'(push_acc) - CntW'(pop_cnt);
      instret <= instret + INSTRET_W'(push_acc);
    end
  end

  // Storage needs no reset: only entries between rd_ptr and wr_ptr are ever presented.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      for (int i = 0; i < IssueWidth; i++) begin
        if (bus.ret_valid[i]) begin
          mem[wr_ptr + PtrW'(lane_off[i])] <= bus.ret_rec[i];
        end
      end
    end
  end

  always_comb begin
    bus.drain_valid = '0;
    bus.drain_rec   = '0;
    for (int k = 0; k < DrainWidth; k++) begin
      bus.drain_valid[k] = CntW'(k) < count;
      bus.drain_rec[k]   = mem[rd_ptr + PtrW'(k)];
    end
    bus.ret_ready = free_slots >= CntW'(IssueWidth);
  end

  assign count_o    = count;
  assign instret_o  = instret;
  assign overflow_o = overflow;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer (IssueWidth 2, DrainWidth 1, Depth 4):
// a record scoreboard plus a table of expected status values after each cycle.
module tb_retire_trace_buffer;
  import retire_trace_buffer_pkg::*;

  localparam int IW = 2;
  localparam int DW = 1;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  count;
  logic [63:0] instret;
  logic        overflow;

  retire_trace_buffer_if #(.IssueWidth(IW), .DrainWidth(DW)) bus ();

  retire_trace_buffer #(.IssueWidth(IW), .DrainWidth(DW), .Depth(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus.slave),
    .count_o    (count),
    .instret_o  (instret),
    .overflow_o (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        dr;
    int          exp_count;
    logic        exp_ready;
    logic        exp_ovf;
    longint      exp_instret;
  } vec_t;

  retire_rec_t sb[$];
  int          m_count;
  int          n_drained;
  int          tests;
  int          failed;
  vec_t        vecs[8];

  function automatic retire_rec_t mk_rec(input logic [31:0] pc);
    retire_rec_t r;
    r.pc       = pc;
    r.instr    = {pc[15:0], 16'h0013};
    r.reg_addr = pc[6:2];
    r.reg_data = ~pc;
    r.mem_addr = pc + 32'h1000;
    r.mem_data = pc ^ 32'h5A5A5A5A;
    r.mem_wrt  = pc[2];
    return r;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rec(input retire_rec_t act, input retire_rec_t exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL drain_rec: got pc 0x%0h (instr 0x%0h), expected pc 0x%0h (instr 0x%0h)",
               act.pc, act.instr, exp.pc, exp.instr);
    end
  endtask

  task automatic do_reset(input int cycles, input logic [1:0] valid, input logic dr);
    rst = 1'b1;
    bus.ret_valid   = valid;
    bus.ret_rec[0]  = mk_rec(32'hBAD0);
    bus.ret_rec[1]  = mk_rec(32'hBAD4);
    bus.drain_ready = dr;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.ret_valid   = '0;
    bus.drain_ready = 1'b0;
    sb.delete();
    m_count = 0;
  endtask

  // One cycle: drive inputs, score the pop against the oldest expected record,
  // then predict acceptance from the model count before the clock edge.
  task automatic apply_stimulus(input logic [1:0] valid, input logic [31:0] pc0,
                                input logic [31:0] pc1, input logic dr);
    int pre;
    int p;
    bus.ret_valid   = valid;
    bus.ret_rec[0]  = mk_rec(pc0);
    bus.ret_rec[1]  = mk_rec(pc1);
    bus.drain_ready = dr;
    pre = m_count;
    check_output("drain_valid", 64'(bus.drain_valid[0]), 64'(pre > 0));
    if (dr && pre > 0) begin
      if (sb.size() == 0) begin
        check_output("scoreboard_empty", 64'(sb.size()), 64'(1));
      end else begin
        check_rec(bus.drain_rec[0], sb.pop_front());
      end
      m_count--;
      n_drained++;
    end
    p = int'(valid[0]) + int'(valid[1]);
    if (p <= DEPTH - pre) begin
      if (valid[0]) sb.push_back(mk_rec(pc0));
      if (valid[1]) sb.push_back(mk_rec(pc1));
      m_count += p;
    end
    @(posedge clk);
    #1;
    bus.ret_valid   = '0;
    bus.drain_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] next_pc;
    tests     = 0;
    failed    = 0;
    m_count   = 0;
    n_drained = 0;
    rst       = 1'b1;
    bus.ret_valid   = '0;
    bus.ret_rec     = '0;
    bus.drain_ready = 1'b0;

    // Reset and idle
    do_reset(2, 2'b00, 1'b0);
    apply_stimulus(2'b00, 32'h0, 32'h0, 1'b0);
    check_output("reset_count", 64'(count), 64'd0);
    check_output("reset_drain_valid", 64'(bus.drain_valid), 64'd0);
    check_output("reset_ret_ready", 64'(bus.ret_ready), 64'd1);
    check_output("reset_instret", instret, 64'd0);
    check_output("reset_overflow", 64'(overflow), 64'd0);

    // Sparse compaction: lane 1 alone, then both lanes
    apply_stimulus(2'b10, 32'hDEAD0000, 32'h104, 1'b0);
    check_output("sparse_count1", 64'(count), 64'd1);
    apply_stimulus(2'b11, 32'h108, 32'h10C, 1'b0);
    check_output("sparse_count3", 64'(count), 64'd3);
    repeat (3) apply_stimulus(2'b00, 32'h0, 32'h0, 1'b1);
    check_output("sparse_instret", instret, 64'd3);
    check_output("sparse_count0", 64'(count), 64'd0);

    // Full, overflow, simultaneous push/pop at full
    vecs[0] = '{2'b11, 32'h200, 32'h204, 1'b0, 2, 1'b1, 1'b0, 2};
    vecs[1] = '{2'b11, 32'h208, 32'h20C, 1'b0, 4, 1'b0, 1'b0, 4};
    vecs[2] = '{2'b01, 32'h210, 32'h0,   1'b0, 4, 1'b0, 1'b1, 4};
    vecs[3] = '{2'b01, 32'h214, 32'h0,   1'b1, 3, 1'b0, 1'b1, 4};
    vecs[4] = '{2'b00, 32'h0,   32'h0,   1'b1, 2, 1'b1, 1'b1, 4};
    vecs[5] = '{2'b11, 32'h218, 32'h21C, 1'b1, 3, 1'b0, 1'b1, 6};
    vecs[6] = '{2'b10, 32'h0,   32'h220, 1'b0, 4, 1'b0, 1'b1, 7};
    vecs[7] = '{2'b00, 32'h0,   32'h0,   1'b1, 3, 1'b0, 1'b1, 7};
    do_reset(1, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].pc0, vecs[i].pc1, vecs[i].dr);
      check_output($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
      check_output($sformatf("vec%0d_ret_ready", i), 64'(bus.ret_ready), 64'(vecs[i].exp_ready));
      check_output($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].exp_ovf));
      check_output($sformatf("vec%0d_instret", i), instret, 64'(vecs[i].exp_instret));
    end

    // Reset mid-stream with three records held and a push in the reset cycle
    do_reset(1, 2'b11, 1'b1);
    check_output("midrst_count", 64'(count), 64'd0);
    check_output("midrst_instret", instret, 64'd0);
    check_output("midrst_overflow", 64'(overflow), 64'd0);
    check_output("midrst_drain_valid", 64'(bus.drain_valid), 64'd0);
    check_output("midrst_ret_ready", 64'(bus.ret_ready), 64'd1);

    // Wrap-around: 16 records through a 4-deep buffer, stalling on ret_ready
    n_drained = 0;
    next_pc   = 32'h0;
    for (int cyc = 0; cyc < 200 && (next_pc <= 32'h3C || m_count > 0); cyc++) begin
      if (next_pc <= 32'h3C && bus.ret_ready) begin
        apply_stimulus(2'b11, next_pc, next_pc + 32'h4, 1'b1);
        next_pc = next_pc + 32'h8;
      end else begin
        apply_stimulus(2'b00, 32'h0, 32'h0, 1'b1);
      end
    end
    check_output("wrap_drained", 64'(n_drained), 64'd16);
    check_output("wrap_count", 64'(count), 64'd0);
    check_output("wrap_overflow", 64'(overflow), 64'd0);
    check_output("wrap_instret", instret, 64'd16);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
